// File: rtl/enforce_constraint_pkg.sv
// Shared types for the Verlet distance-constraint stage.
// Positions are signed Q16.16.
package enforce_constraint_pkg;

  localparam int DATA_W    = 32;
  localparam int FRAC_BITS = 16;

  typedef logic signed [DATA_W-1:0] pos_t;

  // One unit in Q16.16.
  localparam pos_t REST_LEN_DEFAULT = pos_t'(1 << FRAC_BITS);

  typedef enum logic [1:0] {IDLE, PREV, NEXT, DONE} state_t;

endpackage

// File: rtl/enforce_constraint_axis.sv
// axis_constrain: pulls one axis of a node toward one neighbour.
// The correction is half the overshoot beyond rest_len, floored.
module axis_constrain
  import enforce_constraint_pkg::*;
(
  input  pos_t cur,
  input  pos_t nb,
  input  pos_t rest_len,
  output pos_t cur_out,
  output logic changed
);

  logic signed [DATA_W:0] d;
  logic signed [DATA_W:0] rl;
  logic signed [DATA_W:0] excess;
  logic [DATA_W-1:0]      half;

  // Separation at 33 bits so no pair of Q16.16 inputs can wrap.
  // The excess is non-negative, so dropping its LSB is a floor.
  always_comb begin
    d  = {cur[DATA_W-1], cur} - {nb[DATA_W-1], nb};
    rl = {1'b0, rest_len};
    if (d > rl)       excess = d - rl;
    else if (d < -rl) excess = -d - rl;
    else              excess = '0;
    half = excess[DATA_W:1];
    // Result lies between cur and nb, so truncating to 32 bits is exact.
    if (d > rl)       cur_out = cur - half;
    else if (d < -rl) cur_out = cur + half;
    else              cur_out = cur;
    changed = (cur_out != cur);
  end

endmodule

// File: rtl/enforce_constraint.sv
// enforce_constraint: relaxes one rope/cloth node toward its previous
// and then its next neighbour, one pass per cycle, x and y in parallel.
// Optional macro ENFORCE_CONSTRAINT_STATS_EN adds a saturating corr_count.
module enforce_constraint
  import enforce_constraint_pkg::*;
#(
  parameter int   NODE_INDEX = 0,
  parameter pos_t REST_LEN   = REST_LEN_DEFAULT,
  parameter bit   PINNED     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prev_valid,
  input  logic [DATA_W-1:0] prev_x,
  input  logic [DATA_W-1:0] prev_y,
  input  logic [DATA_W-1:0] cur_x,
  input  logic [DATA_W-1:0] cur_y,
  input  logic              next_valid,
  input  logic [DATA_W-1:0] next_x,
  input  logic [DATA_W-1:0] next_y,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] new_x,
`ifdef ENFORCE_CONSTRAINT_STATS_EN
  output logic [15:0]       corr_count,
`endif
  output logic [DATA_W-1:0] new_y
);

  // NODE_INDEX only labels the instance; reject nonsense at elaboration.
  if (NODE_INDEX < 0) begin : g_bad_node_index
    $error("NODE_INDEX must be non-negative");
  end

  state_t state, state_nxt;
  logic   load, step, finish, use_next;

  pos_t   cap_px, cap_py, cap_nx, cap_ny;
  logic   cap_pv, cap_nv;
  pos_t   wx, wy;
  pos_t   nb_x, nb_y, ax_x, ax_y;
  logic   chg_x, chg_y, any_chg;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Sequencing: capture, prev pass, next pass, publish.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    use_next  = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = PREV;
      end
      PREV: begin
        step      = cap_pv && !PINNED;
        state_nxt = NEXT;
      end
      NEXT: begin
        use_next  = 1'b1;
        step      = cap_nv && !PINNED;
        state_nxt = DONE;
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign nb_x = use_next ? cap_nx : cap_px;
  assign nb_y = use_next ? cap_ny : cap_py;

  axis_constrain u_ax_x (.cur(wx), .nb(nb_x), .rest_len(REST_LEN), .cur_out(ax_x), .changed(chg_x));
  axis_constrain u_ax_y (.cur(wy), .nb(nb_y), .rest_len(REST_LEN), .cur_out(ax_y), .changed(chg_y));

  // Working position, captured neighbours and registered result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_px  <= '0;
      cap_py  <= '0;
      cap_nx  <= '0;
      cap_ny  <= '0;
      cap_pv  <= 1'b0;
      cap_nv  <= 1'b0;
      wx      <= '0;
      wy      <= '0;
      any_chg <= 1'b0;
      done    <= 1'b0;
      new_x   <= '0;
      new_y   <= '0;
    end else begin
      done <= finish;
      if (load) begin
        cap_px  <= prev_x;
        cap_py  <= prev_y;
        cap_nx  <= next_x;
        cap_ny  <= next_y;
        cap_pv  <= prev_valid;
        cap_nv  <= next_valid;
        wx      <= cur_x;
        wy      <= cur_y;
        any_chg <= 1'b0;
      end
      if (step) begin
        wx      <= ax_x;
        wy      <= ax_y;
        any_chg <= any_chg | chg_x | chg_y;
      end
      if (finish) begin
        new_x <= wx;
        new_y <= wy;
      end
    end
  end

`ifdef ENFORCE_CONSTRAINT_STATS_EN
  // Count results that moved the node; sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  corr_count <= '0;
    else if (finish && any_chg && corr_count != 16'hFFFF) corr_count <= corr_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_enforce_constraint.sv
// Directed bench: one free node and one pinned node share the stimulus.
// Expected results are queued at start and popped when done pulses.
module tb_enforce_constraint;

  logic        clk = 1'b0;
  logic        reset, start, prev_valid, next_valid;
  logic [31:0] prev_x, prev_y, cur_x, cur_y, next_x, next_y;
  logic        busy_a, done_a, busy_p, done_p;
  logic [31:0] nx_a, ny_a, nx_p, ny_p;
`ifdef ENFORCE_CONSTRAINT_STATS_EN
  logic [15:0] cc_a, cc_p;
  logic [15:0] exp_corr = 16'd0;
`endif

  typedef struct {
    logic [31:0] x, y, px, py;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  enforce_constraint #(.NODE_INDEX(1), .REST_LEN(32'h0001_0000), .PINNED(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .prev_valid(prev_valid), .prev_x(prev_x), .prev_y(prev_y),
    .cur_x(cur_x), .cur_y(cur_y),
    .next_valid(next_valid), .next_x(next_x), .next_y(next_y),
    .busy(busy_a), .done(done_a), .new_x(nx_a),
`ifdef ENFORCE_CONSTRAINT_STATS_EN
    .corr_count(cc_a),
`endif
    .new_y(ny_a));

  enforce_constraint #(.NODE_INDEX(0), .REST_LEN(32'h0001_0000), .PINNED(1'b1)) dut_pin (
    .clk(clk), .reset(reset), .start(start),
    .prev_valid(prev_valid), .prev_x(prev_x), .prev_y(prev_y),
    .cur_x(cur_x), .cur_y(cur_y),
    .next_valid(next_valid), .next_x(next_x), .next_y(next_y),
    .busy(busy_p), .done(done_p), .new_x(nx_p),
`ifdef ENFORCE_CONSTRAINT_STATS_EN
    .corr_count(cc_p),
`endif
    .new_y(ny_p));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] px, py, cx, cy,
                       input logic nv, input logic [31:0] nx, ny);
    prev_valid = pv; prev_x = px; prev_y = py;
    cur_x = cx; cur_y = cy;
    next_valid = nv; next_x = nx; next_y = ny;
  endtask

  // One request; optionally a second start with other data while busy.
  task automatic run(input string tag, input logic pv, input logic [31:0] px, py, cx, cy,
                     input logic nv, input logic [31:0] nx, ny,
                     input logic [31:0] ex, ey, input bit interfere, input bit chg);
    exp_t e;
    int   s;
    int   ndone = 0;
    @(negedge clk);
    drive(pv, px, py, cx, cy, nv, nx, ny);
    start = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    sb.push_back('{ex, ey, cx, cy});
`ifdef ENFORCE_CONSTRAINT_STATS_EN
    if (chg && exp_corr != 16'hFFFF) exp_corr = exp_corr + 16'd1;
`else
    if (chg) ndone = 0;
`endif
    @(negedge clk);
    chk({tag, "_busy"}, {31'd0, busy_a}, 32'd1);
    if (interfere) begin
      drive(1'b1, 32'h0, 32'h0, 32'h0050_0000, 32'h0050_0000, 1'b1, 32'h0, 32'h0);
      start = 1'b1;
    end else start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_a) begin
        ndone++;
        chk({tag, "_latency"}, 32'(cyc - s), 32'd3);
        chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, "_new_x"}, nx_a, e.x);
          chk({tag, "_new_y"}, ny_a, e.y);
          chk({tag, "_pin_done"}, {31'd0, done_p}, 32'd1);
          chk({tag, "_pin_x"}, nx_p, e.px);
          chk({tag, "_pin_y"}, ny_p, e.py);
        end
      end
    end
    chk({tag, "_done_pulses"}, 32'(ndone), 32'd1);
    chk({tag, "_idle"}, {31'd0, busy_a}, 32'd0);
    chk({tag, "_held_x"}, nx_a, e.x);
`ifdef ENFORCE_CONSTRAINT_STATS_EN
    chk({tag, "_corr"}, {16'd0, cc_a}, {16'd0, exp_corr});
    chk({tag, "_pin_corr"}, {16'd0, cc_p}, 32'd0);
`endif
  endtask

  initial begin
    int nd;
    reset = 1'b1;
    start = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_new_x", nx_a, 32'h0);
    chk("rst_new_y", ny_a, 32'h0);
    reset = 1'b0;

    // Pulled in from -3.0 by half the 2.0 overshoot.
    run("t1", 1, 32'hFFFD_0000, 32'h0, 32'h0, 32'h0, 1, 32'h0, 32'h0,
        32'hFFFF_0000, 32'h0, 0, 1);
    // Both neighbours within rest length.
    run("t2", 1, 32'h0000_8000, 32'h0000_8000, 32'h0, 32'h0, 1, 32'hFFFF_8000, 32'hFFFF_8000,
        32'h0, 32'h0, 0, 0);
    // Chain head: only the next neighbour pulls.
    run("t3", 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32'h0004_0000, 32'h0,
        32'h0001_8000, 32'h0, 0, 1);
    // Two passes: x 1->8->4.5, y 2->1.5->1.25; pinned copy keeps cur.
    run("t4", 1, 32'h0010_0000, 32'h0, 32'h0001_0000, 32'h0002_0000, 1, 32'h0, 32'h0,
        32'h0004_8000, 32'h0001_4000, 0, 1);
    // Odd overshoot floors; full-range y separation needs the 33rd bit.
    run("t5", 1, 32'hFFFC_0001, 32'h8000_0000, 32'h0, 32'h7FFF_0000, 0, 32'h0, 32'h0,
        32'hFFFE_8001, 32'h0, 0, 1);
    // Separation exactly equal to rest length on every side: untouched.
    run("t6", 1, 32'hFFFF_0000, 32'h0001_0000, 32'h0, 32'h0, 1, 32'h0001_0000, 32'hFFFF_0000,
        32'h0, 32'h0, 0, 0);
    // Second start while busy is dropped.
    run("t7", 0, 32'h0, 32'h0, 32'h0002_0000, 32'h0001_0000, 1, 32'h0, 32'h0,
        32'h0001_8000, 32'h0001_0000, 1, 1);

    // Reset one cycle into an operation aborts it.
    @(negedge clk);
    drive(1'b1, 32'hFFFD_0000, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    chk("abort_done", 32'(nd), 32'd0);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_new_x", nx_a, 32'h0);
    chk("abort_new_y", ny_a, 32'h0);
`ifdef ENFORCE_CONSTRAINT_STATS_EN
    exp_corr = 16'd0;
    chk("abort_corr", {16'd0, cc_a}, 32'd0);
`endif
    run("t8", 1, 32'hFFFD_0000, 32'h0, 32'h0, 32'h0, 1, 32'h0, 32'h0,
        32'hFFFF_0000, 32'h0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
